adc_serial_sampler: RTL and testbench
=====================================

// Module: adc_serial_sampler
// PURPOSE
//  Upstream stage of the PWM generator. Periodically reads one conversion from a
//  12-bit serial ADC (16-clock frame: 4 leading zeros, then 12 data bits MSB first)
//  and drives a stable, registered 4-bit level (top 4 data bits) onto the PWM
//  generator's ADC input. The block generates the ADC chip-select and serial clock.
// PARAMETERS
//  CLK_DIV        4     cLK cycles per sCLK half-period (>=1)
//  SAMPLE_PERIOD  1000  cLK cycles that cS_N stays high between frames (>=2)
//  FRAME_BITS     16    sCLK cycles per frame (4 leading zeros + 12 data)
//  OUT_BITS       4     output width, taken from data bits [11:12-OUT_BITS]
// PORTS
//  cLK        in   1         system clock; all logic on rising edge
//  rST        in   1         synchronous reset, active-high
//  sDATA      in   1         serial data from ADC (MISO)
//  cS_N       out  1         ADC chip select, active-low
//  sCLK       out  1         ADC serial clock, idles high
//  ADC        out  OUT_BITS  latched level to PWM generator, held between frames
//  vALID      out  1         one-cycle pulse when ADC is updated
//  fRAME_ERR  out  1         one-cycle pulse when a frame is rejected
//  bUSY       out  1         high while cS_N is low
// BEHAVIOUR
//  - Reset (rST=1 on a cLK edge): state IDLE, cS_N=1, sCLK=1, ADC=0, vALID=0,
//    fRAME_ERR=0, bUSY=0, all counters/shift register cleared. Reset wins over
//    every other event, including mid-frame; the frame is abandoned, no update.
//  - FSM: IDLE -> SETUP -> SHIFT -> DONE -> IDLE.
//  - IDLE: cS_N=1, sCLK=1; wait counter runs 0..SAMPLE_PERIOD-1; on last count go
//    to SETUP. First frame after reset starts SAMPLE_PERIOD cycles after reset.
//  - SETUP: cS_N=0, sCLK=1, bUSY=1 for CLK_DIV cycles, then SHIFT.
//  - SHIFT: FRAME_BITS bit slots, each 2*CLK_DIV cycles: sCLK=0 for CLK_DIV, then
//    sCLK=1 for CLK_DIV. sDATA is captured (shift left, LSB in) on the cLK edge
//    where sCLK goes 0->1. After the last slot's high phase go to DONE.
//  - DONE (1 cycle): cS_N=1, bUSY=0. If shift[15:12]==0: ADC<=shift[11:8],
//    vALID=1. Else: ADC unchanged, fRAME_ERR=1. Then IDLE, wait counter restarts.
//  - vALID and fRAME_ERR are mutually exclusive, never high outside DONE.
//  - Frame length (cS_N low) = CLK_DIV + 2*CLK_DIV*FRAME_BITS cycles = 132 @ default.
//  - ADC changes only in DONE; it is glitch-free for the PWM generator.
//  - sCLK, cS_N are registered outputs (no combinational paths from sDATA).
//  - No truncation rounding: ADC is the plain top OUT_BITS of the 12-bit result.
// TESTING
//  1 Reset: hold rST 3 cycles mid-frame -> next cycle cS_N=1, sCLK=1, ADC=0,
//    bUSY=0; no vALID until a full new frame completes.
//  2 Timing: defaults -> cS_N low exactly 132 cycles, 16 sCLK rising edges,
//    sCLK period 8 cycles, cS_N high 1000+1 cycles between frames.
//  3 Data: model ADC sends 0x0A5C -> after DONE ADC=4'hA, vALID one cycle.
//  4 Bounds: frame 0x0FFF -> ADC=4'hF; frame 0x00FF -> ADC=4'h0; both vALID.
//  5 Error: frame 0x2A5C (leading bits 0010) -> fRAME_ERR one cycle, vALID=0,
//    ADC keeps previous value 4'hA.
//  6 Integration: drive ADC into PWM_GENERATOR, ramp model 0x000..0xFFF in 0x100
//    steps -> PWM duty steps through all 16 levels in order.

Source files
------------

// File: rtl/adc_serial_sampler.sv
// Periodic reader for a 12-bit serial ADC. It generates the chip select and the serial clock,
// shifts in one frame, and presents the top data bits as a registered, glitch-free level.
module adc_serial_sampler #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int FRAME_BITS    = 16,
    parameter int OUT_BITS      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sdata,
    output logic                cs_n,
    output logic                sclk,
    output logic [OUT_BITS-1:0] adc,
    output logic                valid,
    output logic                frame_err,
    output logic                busy
);

    localparam int DATA_BITS = 12;
    localparam int CNT_MAX   = (SAMPLE_PERIOD > 2*CLK_DIV) ? SAMPLE_PERIOD : 2*CLK_DIV;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int BIT_W     = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0] HALF      = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(2*CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [BIT_W-1:0]        bit_reg, bit_next;
    logic [FRAME_BITS-1:0]   shift_reg, shift_next;
    logic [OUT_BITS-1:0]     adc_reg, adc_next;
    logic                    valid_reg, valid_next;
    logic                    err_reg, err_next;
    logic                    cs_n_reg, cs_n_next;
    logic                    sclk_reg, sclk_next;
    logic                    busy_reg, busy_next;
    logic                    lead_zero;

    // A frame is trusted only if the ADC really sent its leading zeros.
    assign lead_zero = ~|shift_reg[FRAME_BITS-1:DATA_BITS];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        bit_next   = bit_reg;
        shift_next = shift_reg;
        adc_next   = adc_reg;
        valid_next = 1'b0;
        err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cnt_reg == WAIT_LAST) begin
                    state_next = SETUP;
                    cnt_next   = '0;
                    shift_next = '0;
                end
            end
            SETUP: begin
                if (cnt_reg == HALF_LAST) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    bit_next   = '0;
                end
            end
            SHIFT: begin
                // This edge is the one where sclk rises, so the ADC bit is stable here.
                if (cnt_reg == HALF_LAST) begin
                    shift_next = {shift_reg[FRAME_BITS-2:0], sdata};
                end
                if (cnt_reg == SLOT_LAST) begin
                    cnt_next = '0;
                    if (bit_reg == BIT_LAST) begin
                        state_next = DONE;
                        if (lead_zero) begin
                            adc_next   = shift_reg[DATA_BITS-1 -: OUT_BITS];
                            valid_next = 1'b1;
                        end else begin
                            err_next   = 1'b1;
                        end
                    end else begin
                        bit_next = bit_reg + BIT_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Pin levels are derived from the upcoming state so they leave the block registered.
        cs_n_next = !((state_next == SETUP) || (state_next == SHIFT));
        sclk_next = !((state_next == SHIFT) && (cnt_next < HALF));
        busy_next = !cs_n_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            adc_reg   <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            cs_n_reg  <= 1'b1;
            sclk_reg  <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            adc_reg   <= adc_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
            cs_n_reg  <= cs_n_next;
            sclk_reg  <= sclk_next;
            busy_reg  <= busy_next;
        end
    end

    assign cs_n      = cs_n_reg;
    assign sclk      = sclk_reg;
    assign adc       = adc_reg;
    assign valid     = valid_reg;
    assign frame_err = err_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_adc_serial_sampler.sv
// Bench for adc_serial_sampler: a serial ADC model feeds queued words, and a per-cycle
// monitor checks frame timing, pulses and the held level against frame-level rules.
module tb_adc_serial_sampler;

    localparam int CLK_DIV       = 4;
    localparam int SAMPLE_PERIOD = 1000;
    localparam int FRAME_BITS    = 16;
    localparam int OUT_BITS      = 4;

    localparam int EXP_LOW      = 132;
    localparam int EXP_RISES    = 16;
    localparam int EXP_PERIOD   = 8;
    localparam int EXP_GAP      = 1001;
    localparam int EXP_GAP_RST  = 1000;
    localparam int NUM_WORDS    = 30;
    localparam int FRAMES_AFTER = NUM_WORDS - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                sdata = 1'b0;
    logic                cs_n;
    logic                sclk;
    logic [OUT_BITS-1:0] adc;
    logic                valid;
    logic                frame_err;
    logic                busy;

    int tests = 0;
    int fails = 0;
    int frames_done = 0;

    logic [15:0] words [NUM_WORDS];
    logic [3:0]  lit   [NUM_WORDS];
    bit          has_lit [NUM_WORDS];

    always #5 clk = ~clk;

    adc_serial_sampler #(
        .CLK_DIV      (CLK_DIV),
        .SAMPLE_PERIOD(SAMPLE_PERIOD),
        .FRAME_BITS   (FRAME_BITS),
        .OUT_BITS     (OUT_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sdata    (sdata),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .adc      (adc),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ADC model and monitor: runs on the falling edge, away from the DUT's active edge.
    initial begin : monitor
        int          cyc = 0;
        int          gap = 0;
        int          exp_gap = EXP_GAP_RST;
        int          low_cnt = 0;
        int          rises = 0;
        int          last_rise = -1;
        int          idx = 0;
        int          wptr = 0;
        int          frame_no = 0;
        bit          ok;
        logic        prev_cs = 1'b1;
        logic        prev_sclk = 1'b1;
        logic        was_rst = 1'b1;
        logic [15:0] cur_word = '0;
        logic [3:0]  model_adc = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                was_rst   = 1'b1;
                prev_cs   = 1'b1;
                prev_sclk = 1'b1;
                idx       = 0;
                model_adc = '0;
                sdata     = 1'b0;
                continue;
            end
            if (was_rst) begin
                check("reset_cs_n", cs_n, 1);
                check("reset_sclk", sclk, 1);
                check("reset_adc", adc, 0);
                check("reset_busy", busy, 0);
                check("reset_valid", valid, 0);
                check("reset_frame_err", frame_err, 0);
                was_rst = 1'b0;
                gap     = 0;
                exp_gap = EXP_GAP_RST;
            end
            if (cs_n && !prev_cs) begin
                ok = (cur_word[15:12] == 4'h0);
                if (ok) model_adc = cur_word[11:8];
                check("done_valid", valid, int'(ok));
                check("done_frame_err", frame_err, int'(!ok));
                check("done_adc", adc, model_adc);
                check("frame_low_cycles", low_cnt, EXP_LOW);
                check("frame_sclk_rises", rises, EXP_RISES);
                if (has_lit[frame_no]) check("done_adc_literal", adc, lit[frame_no]);
                $display("[TB] frame %0d word=%h adc=%h valid=%0b frame_err=%0b", frame_no, cur_word, adc, valid, frame_err);
                frames_done++;
                gap     = 0;
                exp_gap = EXP_GAP;
            end else begin
                check("pulses_quiet", {valid, frame_err}, 0);
                check("adc_held", adc, model_adc);
            end
            check("busy_vs_cs_n", busy, int'(!cs_n));
            if (cs_n) begin
                check("sclk_idle_high", sclk, 1);
                gap++;
            end
            if (!cs_n && prev_cs) begin
                check("cs_n_high_gap", gap, exp_gap);
                frame_no  = wptr;
                cur_word  = (wptr < NUM_WORDS) ? words[wptr] : 16'(($urandom) & 32'h0FFF);
                wptr++;
                idx       = 0;
                rises     = 0;
                low_cnt   = 0;
                last_rise = -1;
            end
            if (!cs_n) begin
                low_cnt++;
                if (sclk && !prev_sclk) begin
                    rises++;
                    if (last_rise >= 0) check("sclk_period", cyc - last_rise, EXP_PERIOD);
                    last_rise = cyc;
                    idx++;
                end
            end
            sdata     = (!cs_n && idx < 16) ? cur_word[15 - idx] : 1'b0;
            prev_cs   = cs_n;
            prev_sclk = sclk;
        end
    end

    initial begin : stimulus
        int      n;
        logic [7:0]  low;
        logic [3:0]  lead;
        for (int i = 0; i < NUM_WORDS; i++) has_lit[i] = 1'b0;
        words[0] = 16'h0C00;
        words[1] = 16'h0A5C; lit[1] = 4'hA; has_lit[1] = 1'b1;
        words[2] = 16'h0FFF; lit[2] = 4'hF; has_lit[2] = 1'b1;
        words[3] = 16'h00FF; lit[3] = 4'h0; has_lit[3] = 1'b1;
        words[4] = 16'h0A5C; lit[4] = 4'hA; has_lit[4] = 1'b1;
        words[5] = 16'h2A5C; lit[5] = 4'hA; has_lit[5] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            low = 8'($urandom);
            words[6 + i]   = {4'h0, 4'(i), low};
            lit[6 + i]     = 4'(i);
            has_lit[6 + i] = 1'b1;
        end
        for (int i = 22; i < NUM_WORDS; i++) begin
            low  = 8'($urandom);
            lead = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            words[i] = {lead, 4'($urandom), low};
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        n = 0;
        while (cs_n && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("first_frame_started", cs_n, 0);

        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        n = 0;
        while (frames_done < FRAMES_AFTER && n < 40000) begin
            @(posedge clk);
            n++;
        end
        check("frames_completed", frames_done, FRAMES_AFTER);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
